// File: rtl/control_unit.sv
// Main decoder for the single-cycle MIPS CPU: combinational op/func decode,
// gated to NOP until the first clock after reset, plus a sticky illegal flag.
module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] func,
  output logic [3:0] ALUctr,
  output logic       RegWr,
  output logic       ALUSrc,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       MemWr,
  output logic       Branch,
  output logic       Jump,
  output logic       Extop,
  output logic       Illegal
);

  typedef enum logic {
    ST_NOP    = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_LUI = 4'b1000;

  // Control bundle order: RegWr ALUSrc RegDst MemtoReg MemWr Branch Jump Extop
  localparam logic [7:0] CTL_RTYPE = 8'b1010_0000;
  localparam logic [7:0] CTL_JUMP  = 8'b0000_0010;
  localparam logic [7:0] CTL_IMMS  = 8'b1100_0001;
  localparam logic [7:0] CTL_IMMZ  = 8'b1100_0000;
  localparam logic [7:0] CTL_LW    = 8'b1101_0001;
  localparam logic [7:0] CTL_SW    = 8'b0100_1001;
  localparam logic [7:0] CTL_BEQ   = 8'b0000_0101;

  state_t     state;
  state_t     stateNext;
  logic       illegalQ;
  logic       illegalNext;
  logic [7:0] decCtl;
  logic [3:0] decAlu;
  logic       decIllegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_NOP;
      illegalQ <= 1'b0;
    end else begin
      state    <= stateNext;
      illegalQ <= illegalNext;
    end
  end

  // Unknown encodings fall through to the zero/ADD defaults and raise decIllegal
  always_comb begin
    decCtl     = 8'b0;
    decAlu     = ALU_ADD;
    decIllegal = 1'b0;
    unique case (op)
      6'b000000: begin
        unique case (func)
          6'b100000: begin decCtl = CTL_RTYPE; decAlu = ALU_ADD; end
          6'b100010: begin decCtl = CTL_RTYPE; decAlu = ALU_SUB; end
          6'b100100: begin decCtl = CTL_RTYPE; decAlu = ALU_AND; end
          6'b100101: begin decCtl = CTL_RTYPE; decAlu = ALU_OR;  end
          6'b100110: begin decCtl = CTL_RTYPE; decAlu = ALU_XOR; end
          6'b000000: begin decCtl = CTL_RTYPE; decAlu = ALU_SLL; end
          6'b000010: begin decCtl = CTL_RTYPE; decAlu = ALU_SRL; end
          6'b000011: begin decCtl = CTL_RTYPE; decAlu = ALU_SRA; end
          6'b001000: begin decCtl = CTL_JUMP;  decAlu = ALU_ADD; end
          default:   decIllegal = 1'b1;
        endcase
      end
      6'b001000: begin decCtl = CTL_IMMS; decAlu = ALU_ADD; end
      6'b001100: begin decCtl = CTL_IMMZ; decAlu = ALU_AND; end
      6'b001101: begin decCtl = CTL_IMMZ; decAlu = ALU_OR;  end
      6'b001110: begin decCtl = CTL_IMMZ; decAlu = ALU_XOR; end
      6'b001111: begin decCtl = CTL_IMMZ; decAlu = ALU_LUI; end
      6'b100011: begin decCtl = CTL_LW;   decAlu = ALU_ADD; end
      6'b101011: begin decCtl = CTL_SW;   decAlu = ALU_ADD; end
      6'b000100: begin decCtl = CTL_BEQ;  decAlu = ALU_SUB; end
      6'b000010: begin decCtl = CTL_JUMP; decAlu = ALU_ADD; end
      6'b000011: begin decCtl = CTL_JUMP; decAlu = ALU_ADD; end
      default:   decIllegal = 1'b1;
    endcase
  end

  // Until the first non-reset edge every output is forced to a NOP
  always_comb begin
    stateNext   = ST_ACTIVE;
    illegalNext = illegalQ | decIllegal;
    ALUctr      = ALU_ADD;
    {RegWr, ALUSrc, RegDst, MemtoReg, MemWr, Branch, Jump, Extop} = 8'b0;
    if (state == ST_ACTIVE) begin
      ALUctr = decAlu;
      {RegWr, ALUSrc, RegDst, MemtoReg, MemWr, Branch, Jump, Extop} = decCtl;
    end
  end

  assign Illegal = illegalQ;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: hand-computed decode vectors, NOP-after-reset
// behaviour and the sticky illegal flag.
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [5:0] op;
  logic [5:0] func;
  logic [3:0] ALUctr;
  logic       RegWr, ALUSrc, RegDst, MemtoReg, MemWr, Branch, Jump, Extop, Illegal;

  int checks = 0;
  int errors = 0;

  control_unit dut (
    .clk(clk), .rst(rst), .op(op), .func(func), .ALUctr(ALUctr),
    .RegWr(RegWr), .ALUSrc(ALUSrc), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .MemWr(MemWr), .Branch(Branch), .Jump(Jump), .Extop(Extop), .Illegal(Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge and are sampled 1 time unit later,
  // so a check right after applyStimulus sees purely combinational decode.
  task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f);
    @(negedge clk);
    op   = o;
    func = f;
    #1;
  endtask

  task automatic waitRise();
    @(posedge clk);
    #1;
  endtask

  // Expected bundle order: RegWr ALUSrc RegDst MemtoReg MemWr Branch Jump Extop
  task automatic checkOutput(input string tag, input logic [7:0] expCtl,
                             input logic [3:0] expAlu, input logic expIll);
    logic [12:0] obs;
    logic [12:0] exp;
    obs = {RegWr, ALUSrc, RegDst, MemtoReg, MemWr, Branch, Jump, Extop, ALUctr, Illegal};
    exp = {expCtl, expAlu, expIll};
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed ctl=%b alu=%b ill=%b, expected ctl=%b alu=%b ill=%b",
             tag, obs[12:5], obs[4:1], obs[0], exp[12:5], exp[4:1], exp[0]);
    end
  endtask

  initial begin
    rst  = 1'b1;
    op   = 6'b100011;
    func = 6'b000000;

    waitRise();
    checkOutput("reset_nop_lw", 8'b0000_0000, 4'b0000, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("nop_before_first_edge", 8'b0000_0000, 4'b0000, 1'b0);
    waitRise();
    checkOutput("lw_first_active", 8'b1101_0001, 4'b0000, 1'b0);

    applyStimulus(6'b000000, 6'b100000); checkOutput("add", 8'b1010_0000, 4'b0000, 1'b0);
    applyStimulus(6'b000000, 6'b100010); checkOutput("sub", 8'b1010_0000, 4'b0001, 1'b0);
    applyStimulus(6'b000000, 6'b100100); checkOutput("and", 8'b1010_0000, 4'b0010, 1'b0);
    applyStimulus(6'b000000, 6'b100101); checkOutput("or",  8'b1010_0000, 4'b0011, 1'b0);
    applyStimulus(6'b000000, 6'b100110); checkOutput("xor", 8'b1010_0000, 4'b0100, 1'b0);
    applyStimulus(6'b000000, 6'b000000); checkOutput("sll", 8'b1010_0000, 4'b0101, 1'b0);
    applyStimulus(6'b000000, 6'b000010); checkOutput("srl", 8'b1010_0000, 4'b0110, 1'b0);
    applyStimulus(6'b000000, 6'b000011); checkOutput("sra", 8'b1010_0000, 4'b0111, 1'b0);
    applyStimulus(6'b000000, 6'b001000); checkOutput("jr",  8'b0000_0010, 4'b0000, 1'b0);

    applyStimulus(6'b001000, 6'b111111); checkOutput("addi_func_ignored", 8'b1100_0001, 4'b0000, 1'b0);
    applyStimulus(6'b001100, 6'b000000); checkOutput("andi", 8'b1100_0000, 4'b0010, 1'b0);
    applyStimulus(6'b001101, 6'b000000); checkOutput("ori",  8'b1100_0000, 4'b0011, 1'b0);
    applyStimulus(6'b001110, 6'b000000); checkOutput("xori", 8'b1100_0000, 4'b0100, 1'b0);
    applyStimulus(6'b001111, 6'b000000); checkOutput("lui",  8'b1100_0000, 4'b1000, 1'b0);
    applyStimulus(6'b100011, 6'b000000); checkOutput("lw",   8'b1101_0001, 4'b0000, 1'b0);
    applyStimulus(6'b101011, 6'b000000); checkOutput("sw",   8'b0100_1001, 4'b0000, 1'b0);
    applyStimulus(6'b000100, 6'b000000); checkOutput("beq",  8'b0000_0101, 4'b0001, 1'b0);
    applyStimulus(6'b000010, 6'b000000); checkOutput("j",    8'b0000_0010, 4'b0000, 1'b0);
    applyStimulus(6'b000011, 6'b100000); checkOutput("jal",  8'b0000_0010, 4'b0000, 1'b0);

    // Same falling-edge window: two op changes with no clock edge between them
    @(negedge clk);
    op = 6'b101011; func = 6'b000000;
    #1;
    checkOutput("comb_sw", 8'b0100_1001, 4'b0000, 1'b0);
    op = 6'b000100;
    #1;
    checkOutput("comb_beq", 8'b0000_0101, 4'b0001, 1'b0);

    applyStimulus(6'b111111, 6'b000000);
    checkOutput("illegal_op_comb", 8'b0000_0000, 4'b0000, 1'b0);
    waitRise();
    checkOutput("illegal_op_flag", 8'b0000_0000, 4'b0000, 1'b1);

    applyStimulus(6'b000000, 6'b100000);
    waitRise();
    checkOutput("illegal_sticky", 8'b1010_0000, 4'b0000, 1'b1);

    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_pending", 8'b1010_0000, 4'b0000, 1'b1);
    waitRise();
    checkOutput("rst_midstream", 8'b0000_0000, 4'b0000, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    op = 6'b000000; func = 6'b111111;
    #1;
    checkOutput("illegal_func_nop_state", 8'b0000_0000, 4'b0000, 1'b0);
    waitRise();
    checkOutput("illegal_func_flag", 8'b0000_0000, 4'b0000, 1'b1);

    applyStimulus(6'b001101, 6'b000000);
    checkOutput("ori_after_illegal", 8'b1100_0000, 4'b0011, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
